// File: rtl/axis_m_pktgen.sv
// AXI-Stream packet generator: one start command yields pkt_len beats of incrementing data, tlast on the final beat.
// Latency: beat 0 is presented the cycle after start is sampled; one beat per cycle while tready is high.
// Backpressure: tvalid/tdata/tlast hold until handshake; start is ignored (not queued) while busy.
module axis_m_pktgen #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8,
   parameter int GAP    = 0
) (
   input  logic              m_axis_aclk,
   input  logic              m_axis_areset,
   input  logic              start,
   input  logic [LEN_W-1:0]  pkt_len,
   input  logic [DATA_W-1:0] first_data,
   output logic              busy,
   output logic              done,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tlast
);

   // Gap counter holds GAP-1 down to 0, so it only needs to represent GAP-1.
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t            r_state;
   logic [LEN_W-1:0]  r_remaining;
   logic [DATA_W-1:0] r_data;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic              r_tvalid;
   logic              r_tlast;
   logic              r_busy;
   logic              r_done;

   state_t            w_state_nxt;
   logic [LEN_W-1:0]  w_remaining_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic [GAP_W-1:0]  w_gap_nxt;
   logic              w_tvalid_nxt;
   logic              w_tlast_nxt;
   logic              w_busy_nxt;
   logic              w_done_nxt;
   logic              w_hs;
   logic              w_send;

   // tvalid comes from a register, so tready only influences the next state, never tvalid itself.
   assign w_hs   = r_tvalid & m_axis_tready;
   assign w_send = (r_state == S_SEND);

   // Next-state and next-output computation; every register holds by default, done defaults low.
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_data_nxt      = r_data;
      w_gap_nxt       = r_gap_cnt;
      w_tvalid_nxt    = r_tvalid;
      w_tlast_nxt     = r_tlast;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;

      case (r_state)
         S_IDLE: begin
            // A zero-length request is dropped outright: no beats, no done.
            if (start && (pkt_len != '0)) begin
               w_state_nxt     = S_SEND;
               w_remaining_nxt = pkt_len;
               w_data_nxt      = first_data;
               w_tvalid_nxt    = 1'b1;
               w_tlast_nxt     = (pkt_len == LEN_W'(1));
               w_busy_nxt      = 1'b1;
            end
         end

         S_SEND: begin
            if (w_hs) begin
               if (r_remaining == LEN_W'(1)) begin
                  // Final beat accepted: drop valid, pulse done, optionally enter the gap.
                  w_remaining_nxt = '0;
                  w_tvalid_nxt    = 1'b0;
                  w_tlast_nxt     = 1'b0;
                  w_done_nxt      = 1'b1;
                  if (GAP > 0) begin
                     w_state_nxt = S_GAP;
                     w_gap_nxt   = GAP_W'(GAP - 1);
                     w_busy_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_busy_nxt  = 1'b0;
                  end
               end else begin
                  // Data wraps naturally at the DATA_W boundary.
                  w_remaining_nxt = r_remaining - 1'b1;
                  w_data_nxt      = r_data + 1'b1;
                  w_tlast_nxt     = (r_remaining == LEN_W'(2));
               end
            end
         end

         S_GAP: begin
            // start is deliberately not examined here.
            if (r_gap_cnt == '0) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
            end else begin
               w_gap_nxt = r_gap_cnt - 1'b1;
            end
         end

         default: begin
            w_state_nxt  = S_IDLE;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
            w_busy_nxt   = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything immediately, abandoning any packet.
   always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
      if (m_axis_areset) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_data      <= '0;
         r_gap_cnt   <= '0;
         r_tvalid    <= 1'b0;
         r_tlast     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_data      <= w_data_nxt;
         r_gap_cnt   <= w_gap_nxt;
         r_tvalid    <= w_tvalid_nxt;
         r_tlast     <= w_tlast_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // Payload is zeroed outside SEND so idle cycles never show stale data.
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tdata  = w_send ? r_data  : '0;
   assign m_axis_tlast  = w_send ? r_tlast : 1'b0;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule
